// File: rtl/act_packer_if.sv
// act_packer_if: activation input stream and packed beat output stream
interface act_packer_if #(
   parameter int BITWIDTH = 4,
   parameter int LANES    = 3
);
   logic [BITWIDTH-1:0]       a_tdata;
   logic                      a_tvalid;
   logic                      a_tready;
   logic [BITWIDTH*LANES-1:0] x_tdata;
   logic                      x_tvalid;
   logic                      x_tready;
   modport master (output a_tdata, a_tvalid, x_tready, input a_tready, x_tdata, x_tvalid);
   modport slave  (input a_tdata, a_tvalid, x_tready, output a_tready, x_tdata, x_tvalid);
endinterface

// File: rtl/act_packer.sv
// act_packer: packs activations into LANES-wide beats queued through a small FIFO
module act_packer #(
   parameter int BITWIDTH  = 4,
   parameter int LANES     = 3,
   parameter int NUMINPUTS = 24,
   parameter int DEPTH     = 4
) (
   input  logic        CLK,
   input  logic        RST,
   act_packer_if.slave io,
   input  logic        flush,
   output logic [1:0]  status
);
   localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int FW = NUMINPUTS > 1 ? $clog2(NUMINPUTS) : 1;

   typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, DRAIN = 2'b10, DONE = 2'b11} state_t;

   state_t                          state, state_nx;
   logic [LW-1:0]                   lane;
   logic [FW-1:0]                   frame;
   logic [LANES-1:0][BITWIDTH-1:0]  acc, beat;
   logic [BITWIDTH*LANES-1:0]       mem [DEPTH];
   logic [PW-1:0]                   wptr, rptr;
   logic [CW-1:0]                   count;
   logic                            has_space, a_fire, pop, push;
   logic                            beat_full, frame_last, partial, flush_done;

   assign has_space   = count < CW'(DEPTH);
   assign io.a_tready = RST && (state == IDLE || state == FILL) && (lane != LW'(LANES - 1) || has_space);
   assign a_fire      = io.a_tvalid && io.a_tready;
   assign io.x_tvalid = count != '0;
   assign io.x_tdata  = io.x_tvalid ? mem[rptr] : '0;
   assign pop         = io.x_tvalid && io.x_tready;
   assign beat_full   = a_fire && lane == LW'(LANES - 1);
   assign frame_last  = a_fire && frame == FW'(NUMINPUTS - 1);
   // a flush with anything in the accumulator (including this cycle's activation) emits a zero-padded beat
   assign partial     = state == FILL && flush && !beat_full && (a_fire || lane != '0);
   assign push        = beat_full || (partial && has_space);
   assign flush_done  = state == FILL && flush && (!partial || has_space);
   assign status      = state;

   // accumulator with this cycle's activation dropped into its lane; unfilled lanes stay zero
   always_comb begin
      beat = acc;
      if (a_fire) beat[lane] = io.a_tdata;
   end

   // frame sequencing: fill, drain the FIFO, one DONE cycle, back to idle
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = a_fire ? (frame_last ? DRAIN : FILL) : IDLE;
         FILL:    state_nx = (frame_last || flush_done) ? DRAIN : FILL;
         DRAIN:   state_nx = (count == '0 || (count == CW'(1) && pop)) ? DONE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nx;
   end

   // lane/frame counters, accumulator and FIFO bookkeeping
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         lane  <= '0;
         frame <= '0;
         acc   <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         lane  <= push ? '0 : a_fire ? lane + 1'b1 : lane;
         acc   <= push ? '0 : beat;
         frame <= (frame_last || flush_done) ? '0 : a_fire ? frame + 1'b1 : frame;
         if (push) wptr <= wptr == PW'(DEPTH - 1) ? '0 : wptr + 1'b1;
         if (pop) rptr <= rptr == PW'(DEPTH - 1) ? '0 : rptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage; contents are only observable while count is non-zero
   always_ff @(posedge CLK) begin
      if (push) mem[wptr] <= beat;
   end
endmodule

// File: tb/tb_act_packer.sv
// tb_act_packer: directed checks of packing, backpressure, flush and reset behaviour
module tb_act_packer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  status;
   logic        fired;
   int          total = 0;
   int          bad = 0;
   int          n;
   logic [11:0] q[$];

   act_packer_if #(.BITWIDTH(4), .LANES(3)) io();

   act_packer #(.BITWIDTH(4), .LANES(3), .NUMINPUTS(24), .DEPTH(4)) dut (
      .CLK(clk), .RST(rst_n), .io(io), .flush(flush), .status(status)
   );

   always #5 clk = ~clk;

   // record every beat taken downstream, sampled mid-cycle
   always begin
      @(negedge clk);
      #2;
      if (io.x_tvalid && io.x_tready) q.push_back(io.x_tdata);
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] v);
      io.a_tdata  = v;
      io.a_tvalid = 1'b1;
      for (int i = 0; i < 50 && !io.a_tready; i++) tick();
      chk("send_ready", {31'b0, io.a_tready}, 1);
      tick();
      io.a_tvalid = 1'b0;
   endtask

   function automatic logic [3:0] d(input int k);
      return 4'((k % 15) + 1);
   endfunction

   function automatic logic [11:0] beat(input int k);
      return {d(3 * k + 2), d(3 * k + 1), d(3 * k)};
   endfunction

   initial begin
      io.a_tdata  = '0;
      io.a_tvalid = 1'b0;
      io.x_tready = 1'b0;
      tick();
      chk("rst_status", status, 0);
      chk("rst_a_tready", io.a_tready, 0);
      chk("rst_x_tvalid", io.x_tvalid, 0);
      chk("rst_x_tdata", io.x_tdata, 0);
      rst_n = 1'b1;
      tick();
      chk("rel_status", status, 0);
      chk("rel_x_tvalid", io.x_tvalid, 0);
      chk("rel_a_tready", io.a_tready, 1);

      io.x_tready = 1'b1;
      q.delete();
      send(4'd1);
      send(4'd2);
      send(4'd3);
      chk("pack_x_tvalid", io.x_tvalid, 1);
      chk("pack_x_tdata", io.x_tdata, 12'h321);
      chk("pack_status", status, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush0_status_drain", status, 2);
      chk("pack_q_size", q.size(), 1);
      chk("pack_q0", q[0], 12'h321);
      tick();
      chk("flush0_status_done", status, 3);
      tick();
      chk("flush0_status_idle", status, 0);
      chk("flush0_no_extra_beat", q.size(), 1);

      q.delete();
      send(4'd1);
      chk("frame_status_fill", status, 1);
      for (int i = 0; i < 23; i++) send(4'd1);
      chk("frame_status_drain", status, 2);
      chk("frame_a_tready_drain", io.a_tready, 0);
      tick();
      chk("frame_status_done", status, 3);
      tick();
      chk("frame_status_idle", status, 0);
      chk("frame_q_size", q.size(), 8);
      for (int k = 0; k < 8; k++) chk("frame_beat", q[k], 12'h111);

      q.delete();
      io.x_tready = 1'b0;
      io.a_tvalid = 1'b1;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         io.a_tdata = d(n);
         fired = io.a_tready;
         tick();
         if (fired) n++;
      end
      chk("bp_accepted", n, 14);
      chk("bp_a_tready", io.a_tready, 0);
      chk("bp_x_tvalid", io.x_tvalid, 1);
      chk("bp_x_tdata", io.x_tdata, beat(0));
      io.x_tready = 1'b1;
      for (int c = 0; c < 100 && n < 24; c++) begin
         io.a_tdata = d(n);
         fired = io.a_tready;
         tick();
         if (fired) n++;
      end
      io.a_tvalid = 1'b0;
      chk("bp_total_accepted", n, 24);
      for (int c = 0; c < 30 && status != 2'b00; c++) tick();
      chk("bp_status_idle", status, 0);
      chk("bp_q_size", q.size(), 8);
      for (int k = 0; k < 8; k++) chk("bp_beat", q[k], beat(k));

      q.delete();
      for (int v = 1; v <= 5; v++) send(4'(v));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_status_drain", status, 2);
      tick();
      chk("flush_status_done", status, 3);
      tick();
      chk("flush_status_idle", status, 0);
      chk("flush_q_size", q.size(), 2);
      chk("flush_beat0", q[0], 12'h321);
      chk("flush_beat1", q[1], 12'h054);

      q.delete();
      send(4'd1);
      send(4'd2);
      rst_n = 1'b0;
      #1;
      chk("midrst_status", status, 0);
      chk("midrst_a_tready", io.a_tready, 0);
      chk("midrst_x_tvalid", io.x_tvalid, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_rel_x_tvalid", io.x_tvalid, 0);
      chk("midrst_rel_status", status, 0);
      send(4'd7);
      send(4'd8);
      send(4'd9);
      tick();
      chk("midrst_q_size", q.size(), 1);
      chk("midrst_beat", q[0], 12'h987);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
